// File: rtl/stack_sequencer.sv
// rtl/stack_sequencer.sv - PUSH/POP sequencer driving register-file and byte-memory ports
// Owns the regfile/memory ports while busy; all outputs are decoded from the current state.
module stack_sequencer #(
    parameter logic [3:0] SP_IDX = 4'd10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        op,
    input  logic [3:0]  rp,
    output logic        busy,
    output logic        done,
    output logic [4:0]  rf_read_sel,
    input  logic [15:0] rf_out,
    output logic [4:0]  rf_write_sel,
    output logic        rf_write_en,
    output logic [15:0] rf_data_in,
    output logic [1:0]  rf_ext_op,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ready
);

    typedef enum logic [3:0] {
        S_IDLE, S_LATCH, S_DEC1, S_WR_HI, S_DEC2, S_WR_LO,
        S_RD_LO, S_INC1, S_RD_HI, S_INC2, S_WB, S_DONE
    } state_t;

    localparam logic [1:0] EXT_INC = 2'b01;
    localparam logic [1:0] EXT_DCR = 2'b10;
    localparam logic [4:0] SP_SEL  = {1'b1, SP_IDX};

    state_t      state_q, state_d;
    logic [3:0]  rp_q, rp_d;
    logic [15:0] data_q, data_d;
    logic [7:0]  lo_q, lo_d;
    logic [7:0]  hi_q, hi_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rp_q    <= 4'd0;
            data_q  <= 16'd0;
            lo_q    <= 8'd0;
            hi_q    <= 8'd0;
        end else begin
            state_q <= state_d;
            rp_q    <= rp_d;
            data_q  <= data_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
        end
    end

    assign busy = (state_q != S_IDLE);

    always_comb begin
        state_d      = state_q;
        rp_d         = rp_q;
        data_d       = data_q;
        lo_d         = lo_q;
        hi_d         = hi_q;
        done         = 1'b0;
        rf_read_sel  = 5'd0;
        rf_write_sel = 5'd0;
        rf_write_en  = 1'b0;
        rf_data_in   = 16'd0;
        rf_ext_op    = 2'b00;
        mem_addr     = 16'd0;
        mem_wdata    = 8'd0;
        mem_we       = 1'b0;
        mem_re       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rp_d    = rp;
                    state_d = op ? S_RD_LO : S_LATCH;
                end
            end
            S_LATCH: begin
                rf_read_sel = {1'b1, rp_q};
                data_d      = rf_out;
                state_d     = S_DEC1;
            end
            S_DEC1, S_DEC2: begin
                rf_write_sel = SP_SEL;
                rf_ext_op    = EXT_DCR;
                state_d      = (state_q == S_DEC1) ? S_WR_HI : S_WR_LO;
            end
            // SP was already decremented, so the byte lands at the new SP
            S_WR_HI, S_WR_LO: begin
                rf_read_sel = SP_SEL;
                mem_addr    = rf_out;
                mem_wdata   = (state_q == S_WR_HI) ? data_q[15:8] : data_q[7:0];
                mem_we      = 1'b1;
                if (mem_ready) begin
                    state_d = (state_q == S_WR_HI) ? S_DEC2 : S_DONE;
                end
            end
            S_RD_LO, S_RD_HI: begin
                rf_read_sel = SP_SEL;
                mem_addr    = rf_out;
                mem_re      = 1'b1;
                if (mem_ready) begin
                    if (state_q == S_RD_LO) begin
                        lo_d    = mem_rdata;
                        state_d = S_INC1;
                    end else begin
                        hi_d    = mem_rdata;
                        state_d = S_INC2;
                    end
                end
            end
            S_INC1, S_INC2: begin
                rf_write_sel = SP_SEL;
                rf_ext_op    = EXT_INC;
                state_d      = (state_q == S_INC1) ? S_RD_HI : S_WB;
            end
            S_WB: begin
                rf_write_en  = 1'b1;
                rf_write_sel = {1'b1, rp_q};
                rf_data_in   = {hi_q, lo_q};
                state_d      = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_stack_sequencer.sv
// tb/tb_stack_sequencer.sv - randomized and directed bench for stack_sequencer
// Regfile and memory are behavioural neighbours; a pair/byte-level model predicts results.
module tb_stack_sequencer;

    localparam logic [3:0] SP = 4'd10;

    logic        clk = 1'b0;
    logic        rst, start, op;
    logic [3:0]  rp;
    logic        busy, done;
    logic [4:0]  rf_read_sel, rf_write_sel;
    logic [15:0] rf_out, rf_data_in;
    logic        rf_write_en;
    logic [1:0]  rf_ext_op;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        mem_we, mem_re, mem_ready;

    always #5 clk = ~clk;

    stack_sequencer #(.SP_IDX(SP)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .rp(rp),
        .busy(busy), .done(done),
        .rf_read_sel(rf_read_sel), .rf_out(rf_out),
        .rf_write_sel(rf_write_sel), .rf_write_en(rf_write_en),
        .rf_data_in(rf_data_in), .rf_ext_op(rf_ext_op),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- environment: register file and memory ----------------
    logic [7:0]  rf [16];
    logic [7:0]  mem [65536];
    bit          mem_v [65536];
    logic        poke_en;
    logic [3:0]  poke_idx;
    logic [15:0] poke_val;
    int          plan0, plan1;
    int          acc_idx = 0;
    int          wait_cnt = 0;
    int          ov = 0;

    function automatic logic [7:0] init_byte(input logic [15:0] a);
        return a[15:8] ^ {a[6:0], a[7]} ^ 8'h3C;
    endfunction

    function automatic logic [7:0] mem_peek(input logic [15:0] a);
        return mem_v[a] ? mem[a] : init_byte(a);
    endfunction

    logic [3:0]  rd_lo_idx, ws_hi, ws_lo, pk_lo;
    logic [15:0] wpair, ext_res;
    assign rd_lo_idx = rf_read_sel[3:0] + 4'd1;
    assign ws_hi     = rf_write_sel[3:0];
    assign ws_lo     = rf_write_sel[3:0] + 4'd1;
    assign pk_lo     = poke_idx + 4'd1;
    assign rf_out    = rf_read_sel[4] ? {rf[rf_read_sel[3:0]], rf[rd_lo_idx]} : 16'h0;
    assign wpair     = {rf[ws_hi], rf[ws_lo]};
    assign ext_res   = (rf_ext_op == 2'b01) ? wpair + 16'd1 :
                       (rf_ext_op == 2'b10) ? wpair - 16'd1 : wpair + 16'd2;
    assign mem_rdata = mem_peek(mem_addr);
    assign mem_ready = (acc_idx == 0) ? (wait_cnt >= plan0) : (wait_cnt >= plan1);

    always @(posedge clk) begin
        if (poke_en) begin
            rf[poke_idx] <= poke_val[15:8];
            rf[pk_lo]    <= poke_val[7:0];
        end
        if (rf_ext_op != 2'b00 && rf_write_sel[4]) begin
            rf[ws_hi] <= ext_res[15:8];
            rf[ws_lo] <= ext_res[7:0];
        end
        if (rf_write_en && rf_write_sel[4]) begin
            rf[ws_hi] <= rf_data_in[15:8];
            rf[ws_lo] <= rf_data_in[7:0];
        end
        if (mem_we && mem_ready) begin
            mem[mem_addr]   <= mem_wdata;
            mem_v[mem_addr] <= 1'b1;
        end
        if (rst || done) begin
            acc_idx  <= 0;
            wait_cnt <= 0;
        end else if (mem_we || mem_re) begin
            if (mem_ready) begin
                acc_idx  <= acc_idx + 1;
                wait_cnt <= 0;
            end else begin
                wait_cnt <= wait_cnt + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && ((rf_write_en && rf_ext_op != 2'b00) || (mem_we && mem_re))) ov <= ov + 1;
    end

    // ---------------- reference model ----------------
    logic [7:0]  exp_rf [16];
    logic [7:0]  exp_mem [65536];
    logic [15:0] t_addr0, t_addr1;

    function automatic logic [15:0] exp_pair(input logic [3:0] idx);
        logic [3:0] i1;
        i1 = idx + 4'd1;
        return {exp_rf[idx], exp_rf[i1]};
    endfunction

    task automatic put_pair(input logic [3:0] idx, input logic [15:0] v);
        logic [3:0] i1;
        i1 = idx + 4'd1;
        exp_rf[idx] = v[15:8];
        exp_rf[i1]  = v[7:0];
    endtask

    task automatic model_op(input logic o, input logic [3:0] r);
        logic [15:0] sp, v;
        logic [7:0]  lo, hi;
        sp = exp_pair(SP);
        if (!o) begin
            v  = exp_pair(r);
            sp = sp - 16'd1; exp_mem[sp] = v[15:8]; t_addr0 = sp;
            sp = sp - 16'd1; exp_mem[sp] = v[7:0];  t_addr1 = sp;
            put_pair(SP, sp);
        end else begin
            lo = exp_mem[sp]; t_addr0 = sp; sp = sp + 16'd1;
            hi = exp_mem[sp]; t_addr1 = sp; sp = sp + 16'd1;
            put_pair(SP, sp);
            put_pair(r, {hi, lo});
        end
    endtask

    task automatic set_pair(input logic [3:0] idx, input logic [15:0] v);
        @(negedge clk);
        poke_en = 1'b1; poke_idx = idx; poke_val = v;
        @(negedge clk);
        poke_en = 1'b0;
        put_pair(idx, v);
    endtask

    task automatic compare_state(input string tag);
        for (int i = 0; i < 16; i++) check($sformatf("%s_rf%0d", tag, i), rf[i], exp_rf[i]);
        check({tag, "_mem0"}, mem_peek(t_addr0), exp_mem[t_addr0]);
        check({tag, "_mem1"}, mem_peek(t_addr1), exp_mem[t_addr1]);
        check({tag, "_no_overlap"}, ov, 0);
    endtask

    task automatic run_op(input string tag, input logic o, input logic [3:0] r,
                          input int w0, input int w1, input bit spam,
                          input bit hold_chk, input logic [15:0] hold_a, input logic [7:0] hold_d);
        int cyc;
        int extra;
        plan0 = w0; plan1 = w1;
        model_op(o, r);
        @(negedge clk);
        start = 1'b1; op = o; rp = r;
        @(posedge clk); #1;
        start = 1'b0; op = 1'($urandom); rp = 4'($urandom);
        cyc = 1;
        while (!done && cyc < 60) begin
            if (spam && cyc == 2) begin
                start = 1'b1; op = ~o;
            end
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
            if (hold_chk && cyc >= 3 && cyc <= 6) begin
                check({tag, "_hold_we"}, mem_we, 1'b1);
                check({tag, "_hold_addr"}, mem_addr, hold_a);
                check({tag, "_hold_wdata"}, mem_wdata, hold_d);
            end
        end
        check({tag, "_latency"}, cyc, 6 + w0 + w1);
        extra = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done) extra++;
        end
        check({tag, "_single_done"}, extra, 0);
        check({tag, "_idle"}, busy, 1'b0);
        compare_state(tag);
    endtask

    initial begin
        int cyc;
        rst = 1'b1; start = 1'b0; op = 1'b0; rp = 4'd0;
        poke_en = 1'b0; poke_idx = 4'd0; poke_val = 16'd0;
        plan0 = 0; plan1 = 0;
        for (int a = 0; a < 65536; a++) exp_mem[a] = init_byte(16'(a));
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_outs", {busy, done, rf_read_sel, rf_write_sel, rf_write_en, rf_data_in,
                             rf_ext_op, mem_addr, mem_wdata, mem_we, mem_re}, 64'd0);
        for (int i = 0; i < 16; i += 2) set_pair(4'(i), 16'($urandom));

        set_pair(SP, 16'h2000);
        set_pair(4'd2, 16'hBEEF);
        run_op("push", 1'b0, 4'd2, 0, 0, 0, 0, 16'h0, 8'h0);
        check("push_sp", {rf[10], rf[11]}, 16'h1FFE);
        check("push_hi", mem_peek(16'h1FFF), 8'hBE);
        check("push_lo", mem_peek(16'h1FFE), 8'hEF);

        run_op("pop", 1'b1, 4'd4, 0, 0, 0, 0, 16'h0, 8'h0);
        check("pop_pair", {rf[4], rf[5]}, 16'hBEEF);
        check("pop_sp", {rf[10], rf[11]}, 16'h2000);

        run_op("push_wait", 1'b0, 4'd2, 3, 0, 0, 1, 16'h1FFF, 8'hBE);

        set_pair(SP, 16'h0000);
        set_pair(4'd6, 16'hA55A);
        run_op("push_wrap", 1'b0, 4'd6, 0, 0, 0, 0, 16'h0, 8'h0);
        check("wrap_hi", mem_peek(16'hFFFF), 8'hA5);
        check("wrap_lo", mem_peek(16'hFFFE), 8'h5A);
        check("wrap_sp", {rf[10], rf[11]}, 16'hFFFE);

        set_pair(SP, 16'hFFFF);
        run_op("pop_wrap", 1'b1, 4'd8, 0, 0, 0, 0, 16'h0, 8'h0);
        check("popwrap_sp", {rf[10], rf[11]}, 16'h0001);

        run_op("spam", 1'b0, 4'd12, 1, 1, 1, 0, 16'h0, 8'h0);
        run_op("push_sp", 1'b0, SP, 0, 0, 0, 0, 16'h0, 8'h0);
        run_op("pop_sp", 1'b1, SP, 0, 2, 0, 0, 16'h0, 8'h0);

        // reset while WR_LO waits: SP keeps both decrements, only the high byte landed
        set_pair(SP, 16'h2000);
        set_pair(4'd2, 16'h1234);
        plan0 = 0; plan1 = 5;
        @(negedge clk);
        start = 1'b1; op = 1'b0; rp = 4'd2;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        check("rst_pre_we", {mem_we, mem_addr, mem_wdata}, {1'b1, 16'h1FFE, 8'h34});
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_outs", {busy, done, rf_read_sel, rf_write_sel, rf_write_en, rf_data_in,
                           rf_ext_op, mem_addr, mem_wdata, mem_we, mem_re}, 64'd0);
        check("rst_sp", {rf[10], rf[11]}, 16'h1FFE);
        check("rst_hi", mem_peek(16'h1FFF), 8'h12);
        check("rst_lo", mem_peek(16'h1FFE), exp_mem[16'h1FFE]);
        put_pair(SP, 16'h1FFE);
        exp_mem[16'h1FFF] = 8'h12;

        for (int k = 0; k < 24; k++) begin
            run_op($sformatf("rnd%0d", k), 1'($urandom), 4'(2 * $urandom_range(0, 6)),
                   $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                   0, 16'h0, 8'h0);
        end

        cyc = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
